// File: rtl/dt_pkg.sv
// Shared types and default geometry for the distance-transform result scanner.
package dt_pkg;

   localparam int unsigned DT_IMG_W  = 128;
   localparam int unsigned DT_IMG_H  = 128;
   localparam int unsigned DT_ADDR_W = 14;
   localparam int unsigned DIST_W    = 8;

   typedef logic [DIST_W-1:0] dist_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

   // A pixel belongs to an object when its distance is nonzero.
   function automatic logic is_object(input dist_t d);
      return d != '0;
   endfunction

endpackage

// File: rtl/dt_skid_fifo.sv
// Two-entry FIFO whose head entry is the registered output; push and pop may
// coincide even when full.
module dt_skid_fifo
   import dt_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_push,
   input  dist_t      i_din,
   input  logic       i_pop,
   output logic       o_valid,
   output dist_t      o_dout,
   output logic [1:0] o_count
);

   logic [1:0] r_cnt;
   dist_t      r_d0;
   dist_t      r_d1;
   logic       w_pop;

   assign w_pop = i_pop && (r_cnt != 2'd0);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= 2'd0;
         r_d0  <= '0;
         r_d1  <= '0;
      end else begin
         case ({i_push, w_pop})
            2'b11: begin
               // Occupancy is unchanged; the new word lands behind whatever remains.
               if (r_cnt == 2'd1) begin
                  r_d0 <= i_din;
               end else begin
                  r_d0 <= r_d1;
                  r_d1 <= i_din;
               end
            end
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  r_d0  <= i_din;
                  r_cnt <= 2'd1;
               end else if (r_cnt == 2'd1) begin
                  r_d1  <= i_din;
                  r_cnt <= 2'd2;
               end
            end
            2'b01: begin
               r_d0  <= r_d1;
               r_cnt <= r_cnt - 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_valid = r_cnt != 2'd0;
   assign o_dout  = r_d0;
   assign o_count = r_cnt;

endmodule

// File: rtl/dt_res_scan.sv
// Scans the DT result memory in raster order, collecting max/first-max/object-count
// statistics; the pixel stream and its FIFO exist only with DT_SCAN_STREAM_EN defined.
module dt_res_scan
   import dt_pkg::*;
#(
   parameter int unsigned IMG_W  = DT_IMG_W,
   parameter int unsigned IMG_H  = DT_IMG_H,
   parameter int unsigned ADDR_W = DT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              res_rd,
   output logic [ADDR_W-1:0] res_addr,
   input  dist_t             res_di,
   output logic              px_valid,
   output dist_t             px_data,
   input  logic              px_ready,
   output logic              busy,
   output logic              stat_valid,
   output dist_t             max_dist,
   output logic [ADDR_W-1:0] max_addr,
   output logic [ADDR_W:0]   obj_cnt
);

   localparam int unsigned       NPIX      = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   scan_state_t       r_state;
   scan_state_t       w_state_nxt;
   logic              w_start_ok;
   logic              w_rd;
   logic              w_done_entry;
   logic              w_room;
   logic              w_drained;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_dat_addr;
   logic              r_busy;
   logic              r_stat_valid;
   dist_t             r_max_dist;
   logic [ADDR_W-1:0] r_max_addr;
   logic [ADDR_W:0]   r_obj_cnt;

`ifdef DT_SCAN_STREAM_EN
   logic       w_pop;
   logic [1:0] w_fifo_cnt;

   assign w_pop = px_valid && px_ready;
   // A same-cycle pop frees a slot, which is what lets a ready sink see one beat per cycle.
   assign w_room    = (3'(w_fifo_cnt) + 3'(r_inflight) - 3'(w_pop)) < 3'd2;
   assign w_drained = (w_fifo_cnt == 2'd0) || ((w_fifo_cnt == 2'd1) && w_pop);

   dt_skid_fifo u_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (r_inflight),
      .i_din   (res_di),
      .i_pop   (w_pop),
      .o_valid (px_valid),
      .o_dout  (px_data),
      .o_count (w_fifo_cnt)
   );
`else
   logic w_unused_ready;

   assign w_unused_ready = px_ready;
   assign w_room         = 1'b1;
   assign w_drained      = 1'b1;
   assign px_valid       = 1'b0;
   assign px_data        = '0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) w_state_nxt = ST_READ;
         end
         ST_READ: begin
            if (w_rd && (r_addr == LAST_ADDR)) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!r_inflight && w_drained) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Per-state control strobes.
   always_comb begin
      w_start_ok   = 1'b0;
      w_rd         = 1'b0;
      w_done_entry = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: w_start_ok   = start;
         ST_READ:          w_rd         = w_room;
         ST_DRAIN:         w_done_entry = !r_inflight && w_drained;
         default: ;
      endcase
   end

   // Read address, in-flight tracking and statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inflight   <= 1'b0;
         r_addr       <= '0;
         r_dat_addr   <= '0;
         r_busy       <= 1'b0;
         r_stat_valid <= 1'b0;
         r_max_dist   <= '0;
         r_max_addr   <= '0;
         r_obj_cnt    <= '0;
      end else begin
         r_inflight <= w_rd;
         if (w_rd) begin
            r_dat_addr <= r_addr;
            if (r_addr != LAST_ADDR) r_addr <= r_addr + ADDR_W'(1);
         end
         if (w_start_ok) begin
            r_addr       <= '0;
            r_busy       <= 1'b1;
            r_stat_valid <= 1'b0;
            r_max_dist   <= '0;
            r_max_addr   <= '0;
            r_obj_cnt    <= '0;
         end else if (r_inflight) begin
            if (is_object(res_di)) r_obj_cnt <= r_obj_cnt + (ADDR_W+1)'(1);
            // Strict compare keeps the earliest address on ties.
            if (res_di > r_max_dist) begin
               r_max_dist <= res_di;
               r_max_addr <= r_dat_addr;
            end
         end
         if (w_done_entry) begin
            r_busy       <= 1'b0;
            r_stat_valid <= 1'b1;
         end
      end
   end

   assign res_rd     = w_rd;
   assign res_addr   = r_addr;
   assign busy       = r_busy;
   assign stat_valid = r_stat_valid;
   assign max_dist   = r_max_dist;
   assign max_addr   = r_max_addr;
   assign obj_cnt    = r_obj_cnt;

endmodule

// File: tb/tb_dt_res_scan.sv
// Self-checking bench for dt_res_scan: synchronous RAM model, read/beat monitors and
// a whole-image reference for the statistics. Stream checks follow DT_SCAN_STREAM_EN.
module tb_dt_res_scan;

   localparam int unsigned IMG_W  = 128;
   localparam int unsigned IMG_H  = 128;
   localparam int unsigned ADDR_W = 14;
   localparam int          NPIX   = IMG_W * IMG_H;
   localparam int          LIMIT  = 40000;

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic              start    = 1'b0;
   logic              px_ready = 1'b1;
   logic              res_rd;
   logic [ADDR_W-1:0] res_addr;
   logic [7:0]        res_di   = '0;
   logic              px_valid;
   logic [7:0]        px_data;
   logic              busy;
   logic              stat_valid;
   logic [7:0]        max_dist;
   logic [ADDR_W-1:0] max_addr;
   logic [ADDR_W:0]   obj_cnt;

   logic [7:0]  mem [NPIX];
   int          checks   = 0;
   int          failures = 0;
   int unsigned rd_q[$];
   logic [7:0]  beat_q[$];
   int          stall_bad = 0;
   logic        r_stall   = 1'b0;
   logic [7:0]  r_held    = '0;

   dt_res_scan #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .res_rd     (res_rd),
      .res_addr   (res_addr),
      .res_di     (res_di),
      .px_valid   (px_valid),
      .px_data    (px_data),
      .px_ready   (px_ready),
      .busy       (busy),
      .stat_valid (stat_valid),
      .max_dist   (max_dist),
      .max_addr   (max_addr),
      .obj_cnt    (obj_cnt)
   );

   always #5 clk = ~clk;

   // Result memory: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (res_rd) res_di <= mem[res_addr];
   end

   // Mid-cycle monitor: reads issued, beats transferred, stall stability.
   always @(negedge clk) begin
      if (res_rd === 1'b1) rd_q.push_back(int'(res_addr));
      if (r_stall && (px_valid !== 1'b1 || px_data !== r_held)) stall_bad <= stall_bad + 1;
      r_stall <= (px_valid === 1'b1) && (px_ready === 1'b0) && !reset;
      r_held  <= px_data;
      if (px_valid === 1'b1 && px_ready === 1'b1) beat_q.push_back(px_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".res_rd"},     64'(res_rd),     0);
      chk({tag, ".res_addr"},   64'(res_addr),   0);
      chk({tag, ".px_valid"},   64'(px_valid),   0);
      chk({tag, ".px_data"},    64'(px_data),    0);
      chk({tag, ".busy"},       64'(busy),       0);
      chk({tag, ".stat_valid"}, 64'(stat_valid), 0);
      chk({tag, ".max_dist"},   64'(max_dist),   0);
      chk({tag, ".max_addr"},   64'(max_addr),   0);
      chk({tag, ".obj_cnt"},    64'(obj_cnt),    0);
   endtask

   // Reference: maximum over the image, then its first raster position.
   task automatic ref_stats(output int mx, output int ma, output int oc);
      mx = 0;
      oc = 0;
      ma = -1;
      for (int i = 0; i < NPIX; i++) begin
         if (mem[i] != 8'd0) oc++;
         if (int'(mem[i]) > mx) mx = int'(mem[i]);
      end
      for (int i = 0; i < NPIX && ma < 0; i++) begin
         if (int'(mem[i]) == mx) ma = i;
      end
   endtask

   task automatic fill_zero();
      for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < NPIX; i++)
         mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 200));
   endtask

   task automatic run_scan(input string tag, input bit rnd, input int again, output int lat);
      start    = 1'b1;
      px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      lat = 1;
      chk({tag, ".busy_after_start"},  64'(busy),       1);
      chk({tag, ".stat_cleared"},      64'(stat_valid), 0);
      chk({tag, ".obj_cleared"},       64'(obj_cnt),    0);
      chk({tag, ".max_addr_cleared"},  64'(max_addr),   0);
      while (stat_valid !== 1'b1 && lat < LIMIT) begin
         start    = (lat == again);
         px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         lat++;
      end
      start    = 1'b0;
      px_ready = 1'b1;
   endtask

   task automatic check_scan(input string tag, input bit rnd, input int lat,
                             input int rd_base, input int bt_base, input int sb_base);
      int mx, ma, oc, n, bad;
      ref_stats(mx, ma, oc);
      chk({tag, ".stat_valid"}, 64'(stat_valid), 1);
      chk({tag, ".busy_done"},  64'(busy),       0);
      chk({tag, ".max_dist"},   64'(max_dist),   64'(mx));
      chk({tag, ".max_addr"},   64'(max_addr),   64'(ma));
      chk({tag, ".obj_cnt"},    64'(obj_cnt),    64'(oc));
      if (!rnd) chk({tag, ".latency"}, 64'(lat), 64'(NPIX + 3));
      n = rd_q.size() - rd_base;
      chk({tag, ".reads"}, 64'(n), 64'(NPIX));
      bad = 0;
      for (int i = 0; i < n && i < NPIX; i++)
         if (rd_q[rd_base + i] != unsigned'(i)) bad++;
      chk({tag, ".read_order"}, 64'(bad), 0);
`ifdef DT_SCAN_STREAM_EN
      n = beat_q.size() - bt_base;
      chk({tag, ".beats"}, 64'(n), 64'(NPIX));
      bad = 0;
      for (int i = 0; i < n && i < NPIX; i++)
         if (beat_q[bt_base + i] !== mem[i]) bad++;
      chk({tag, ".beat_data"},   64'(bad),                 0);
      chk({tag, ".stall_hold"},  64'(stall_bad - sb_base), 0);
`else
      chk({tag, ".no_beats"},    64'(beat_q.size() - bt_base), 0);
      chk({tag, ".no_stall"},    64'(stall_bad - sb_base),     0);
`endif
   endtask

   initial begin
      int lat, rb, bb, sb;
      fill_zero();
      repeat (3) tick();
      check_reset("reset0");
      reset = 1'b0;
      tick();

      // All-zero image, ready high, stray start during READ.
      rb = rd_q.size(); bb = beat_q.size(); sb = stall_bad;
      run_scan("zero", 1'b0, 1000, lat);
      check_scan("zero", 1'b0, lat, rb, bb, sb);

      // Single object pixel in the middle of the image.
      mem[8256] = 8'd5;
      rb = rd_q.size(); bb = beat_q.size(); sb = stall_bad;
      run_scan("single", 1'b0, -1, lat);
      check_scan("single", 1'b0, lat, rb, bb, sb);
`ifdef DT_SCAN_STREAM_EN
      if (beat_q.size() > bb + 8256) chk("single.beat8256", 64'(beat_q[bb + 8256]), 5);
      else                           chk("single.beat8256_present", 0, 1);
`endif
      repeat (5) tick();
      chk("done.stat_held", 64'(stat_valid), 1);
      chk("done.max_held",  64'(max_dist),   5);

      // Tie on the maximum, restarted straight from DONE.
      mem[8256] = 8'd0;
      mem[300]  = 8'd9;
      mem[700]  = 8'd9;
      rb = rd_q.size(); bb = beat_q.size(); sb = stall_bad;
      run_scan("tie", 1'b0, -1, lat);
      check_scan("tie", 1'b0, lat, rb, bb, sb);

      // Random image and random back-pressure, aborted by reset 5000 cycles in.
      fill_rand();
      start    = 1'b1;
      px_ready = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      repeat (4999) begin
         px_ready = 1'($urandom_range(0, 1));
         tick();
      end
      reset    = 1'b1;
      px_ready = 1'b1;
      tick();
      reset = 1'b0;
      check_reset("abort");
      rb = rd_q.size(); bb = beat_q.size();
      repeat (20) tick();
      chk("abort.no_reads", 64'(rd_q.size() - rb),   0);
      chk("abort.no_beats", 64'(beat_q.size() - bb), 0);

      // Rescan after the abort, still under random back-pressure.
      rb = rd_q.size(); bb = beat_q.size(); sb = stall_bad;
      run_scan("rescan", 1'b1, -1, lat);
      check_scan("rescan", 1'b1, lat, rb, bb, sb);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dt_res_scan.md
DT_RES_SCAN -- requirements
Module: dt_res_scan

Interface
REQ-001 SHALL have parameter IMG_W, default 128: image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 128: image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 14: result-memory address width, equal to log2(IMG_W*IMG_H).
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that starts a scan (driven by the DT done output).
REQ-007 res_rd  out  1  result-memory read strobe.
REQ-008 res_addr  out  ADDR_W  result-memory read address.
REQ-009 res_di  in  8  read data, valid one cycle after the res_rd cycle.
REQ-010 px_valid  out  1  output-stream data valid.
REQ-011 px_data  out  8  output-stream distance value, raster order.
REQ-012 px_ready  in  1  downstream accept for the output stream.
REQ-013 busy  out  1  high from the cycle after an accepted start until DONE is entered.
REQ-014 stat_valid  out  1  statistics valid; held until the next accepted start or reset.
REQ-015 max_dist  out  8  largest distance value found.
REQ-016 max_addr  out  ADDR_W  raster address of the first occurrence of max_dist.
REQ-017 obj_cnt  out  ADDR_W+1  number of nonzero (object) pixels.

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-019 SHALL move IDLE->READ or DONE->READ on start; start SHALL be ignored in READ and DRAIN.
REQ-020 On accepted start, SHALL clear stats, stat_valid and the read address to 0.
REQ-021 In READ, SHALL issue at most one read per cycle, addresses 0..IMG_W*IMG_H-1 in ascending order, with no skipped or repeated addresses.
REQ-022 SHALL hold res_rd low in IDLE, DRAIN and DONE; res_addr is don't-care when res_rd is low.
REQ-023 SHALL move READ->DRAIN in the cycle after issuing the last address; no address wrap-around.
REQ-024 SHALL move DRAIN->DONE when the last datum has returned and the output buffer is empty, asserting stat_valid on the DONE entry cycle.
REQ-025 Stats, per returned datum d at address a:
- obj_cnt += (d!=0);
- when d>max_dist (strict), max_dist=d and max_addr=a; ties keep the earlier address.
REQ-026 All-zero image SHALL give max_dist=0, max_addr=0, obj_cnt=0.
REQ-027 SHALL transfer a stream beat when px_valid && px_ready; px_data SHALL hold stable while px_valid && !px_ready.
REQ-028 SHALL buffer returned data in a 2-entry FIFO, issuing a read only when (entries occupied + reads in flight) < 2; no datum is ever dropped.
REQ-029 A simultaneous FIFO push and pop on a full FIFO SHALL be legal, and the FIFO SHALL stay full.
REQ-030 With px_ready held high, SHALL sustain one beat per cycle; start-to-stat_valid SHALL be IMG_W*IMG_H+3 cycles.

Reset
REQ-031 On reset, SHALL drive: state=IDLE, res_rd=0, res_addr=0, px_valid=0, px_data=0, busy=0, stat_valid=0, max_dist=0, max_addr=0, obj_cnt=0, FIFO empty.
REQ-032 Reset mid-scan SHALL abort immediately, with no further reads or beats; a later start SHALL rescan from address 0.

Configuration
REQ-033 With macro DT_SCAN_STREAM_EN defined, the stream path and FIFO SHALL be present as specified above.
REQ-034 Without DT_SCAN_STREAM_EN:
- FIFO SHALL be absent and px_valid/px_data SHALL be tied 0;
- px_ready SHALL be ignored;
- reads SHALL be issued every cycle in READ;
- the stats and the REQ-030 latency SHALL be unchanged.

Structure
REQ-035 Shared package dt_pkg SHALL hold IMG_W, IMG_H and ADDR_W defaults, the scan-state enum, and the distance type (8-bit).
REQ-036 The FIFO SHALL be a separate sub-module dt_skid_fifo (depth 2, width 8).

Verification
REQ-037 Image all zero, px_ready=1 -> 16384 beats of 0, max_dist=0, obj_cnt=0, stat_valid 16387 cycles after start.
REQ-038 Single nonzero value 5 at address 8256 -> max_dist=5, max_addr=8256, obj_cnt=1, beat 8256 equals 5.
REQ-039 Value 9 at addresses 300 and 700 -> max_addr=300.
REQ-040 px_ready toggled randomly (50%) -> beats arrive in raster order, no loss or duplication, px_data stable while stalled.
REQ-041 Reset at cycle 5000 of a scan, then start -> outputs at reset values, and the rescan begins at address 0 with correct stats.
REQ-042 start pulsed during READ -> ignored; a second start in DONE -> stats cleared and the image rescanned.
